// File: rtl/stage0_pkg.sv
// Shared definitions for the axis_cpu fetch stage: default widths, the age
// saturation constant and the instruction byte type.
package stage0_pkg;

  localparam int DEF_PC_WIDTH    = 10;
  localparam int DEF_COUNT_WIDTH = 6;
  localparam int DEF_COUNT_MAX   = (1 << DEF_COUNT_WIDTH) - 1;
  localparam int INSTR_WIDTH     = 8;

  typedef logic [INSTR_WIDTH-1:0] instr_t;

endpackage

// File: rtl/stage0_if.sv
// Instruction-memory read port plus the decode-side valid/ready channel of
// the fetch stage. The master is the fetch stage; the slave is memory and decode.
interface stage0_if
  import stage0_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);

  logic [PC_WIDTH-1:0]    inst_rd_addr;
  logic                   inst_rd_en;
  instr_t                 inst_rd_data;
  instr_t                 instr_out;
  logic [COUNT_WIDTH-1:0] ocount;
  logic                   PC_en;
  logic                   next_rdy;
  logic                   vld;

  modport master (
    output inst_rd_addr, inst_rd_en, instr_out, ocount, PC_en, vld,
    input  inst_rd_data, next_rdy
  );

  modport slave (
    input  inst_rd_addr, inst_rd_en, instr_out, ocount, PC_en, vld,
    output inst_rd_data, next_rdy
  );

endinterface

// File: rtl/stage0_fetch_buf.sv
// Two-entry instruction FIFO with per-entry saturating age counters and a
// synchronous flush. Entry 0 is always the head.
module fetch_buf
  import stage0_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  instr_t                 push_data,
  input  logic                   pop,
  output instr_t                 head_data,
  output logic [COUNT_WIDTH-1:0] head_count,
  output logic [1:0]             occ
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  function automatic logic [COUNT_WIDTH-1:0] age(input logic [COUNT_WIDTH-1:0] c);
    return (c == COUNT_MAX) ? c : c + COUNT_ONE;
  endfunction

  // A returning byte is one cycle old during its return cycle and ages at the push edge.
  localparam logic [COUNT_WIDTH-1:0] PUSH_COUNT = (COUNT_ONE == COUNT_MAX) ? COUNT_ONE
                                                                           : COUNT_ONE + COUNT_ONE;

  instr_t [1:0]                  data_q, data_d;
  logic   [1:0][COUNT_WIDTH-1:0] count_q, count_d;
  logic   [1:0]                  occ_q, occ_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    data_d     = data_q;
    count_d[0] = age(count_q[0]);
    count_d[1] = age(count_q[1]);
    occ_d      = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          data_d[0]  = push_data;
          count_d[0] = PUSH_COUNT;
        end else begin
          data_d[1]  = push_data;
          count_d[1] = PUSH_COUNT;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        data_d[0]  = data_q[1];
        count_d[0] = age(count_q[1]);
        occ_d      = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data_d[0]  = push_data;
          count_d[0] = PUSH_COUNT;
        end else begin
          data_d[0]  = data_q[1];
          count_d[0] = age(count_q[1]);
          data_d[1]  = push_data;
          count_d[1] = PUSH_COUNT;
        end
      end
      default: ;
    endcase
    if (flush) occ_d = 2'd0;
  end

  // NOTE: the FIFO storage is reset too, so instr_out/ocount read zero straight out of reset.
  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      occ_q   <= occ_d;
    end
  end

  assign head_data  = data_q[0];
  assign head_count = count_q[0];
  assign occ        = occ_q;

endmodule

// File: rtl/stage0.sv
// Fetch stage of the axis_cpu pipeline: PC, in-flight tracking and issue
// control in front of a synchronous-read instruction memory.
module stage0
  import stage0_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_mispredict,
  input  logic [PC_WIDTH-1:0] branch_target,
  stage0_if.master            bus
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          occ;
  logic [2:0]          pending;
  logic                pop;
  logic                issue;

  assign bus.vld = (occ != 2'd0);
  assign pop     = bus.vld && bus.next_rdy && !branch_mispredict;

  // Entries that will be resident or returning after this edge if nothing new is issued.
  assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = !rst && !branch_mispredict && (pending < 3'd2);

  assign bus.inst_rd_en   = issue;
  assign bus.PC_en        = issue;
  assign bus.inst_rd_addr = issue ? pc_q : '0;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    if (branch_mispredict) pc_d = branch_target;
    else if (issue)        pc_d = pc_q + PC_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_buf #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_mispredict),
    .push       (inflight_q),
    .push_data  (bus.inst_rd_data),
    .pop        (pop),
    .head_data  (bus.instr_out),
    .head_count (bus.ocount),
    .occ        (occ)
  );

endmodule

// File: tb/tb_stage0.sv
// Directed bench for stage0: streaming, backpressure, mispredict, PC wrap,
// age saturation and reset-over-mispredict, against a byte-per-address memory.
module tb_stage0;
  import stage0_pkg::*;

  localparam int PW = 10;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          bm;
  logic [PW-1:0] bt;
  int            n_checks = 0;
  int            n_fail   = 0;

  stage0_if #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();

  stage0 #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .branch_mispredict (bm),
    .branch_target     (bt),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  // Memory content: byte at address a is (a + 0x10) mod 256.
  always @(posedge clk)
    if (bus.inst_rd_en) bus.inst_rd_data <= 8'(bus.inst_rd_addr + 10'h010);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bm  = 1'b0;
    bt  = '0;
    bus.next_rdy = 1'b1;

    cyc();
    check("rst_vld",    32'(bus.vld),          32'h0);
    check("rst_en",     32'(bus.inst_rd_en),   32'h0);
    check("rst_pc_en",  32'(bus.PC_en),        32'h0);
    check("rst_addr",   32'(bus.inst_rd_addr), 32'h0);
    check("rst_instr",  32'(bus.instr_out),    32'h0);
    check("rst_ocount", 32'(bus.ocount),       32'h0);

    // R0..R4: streaming from address 0 with decode always ready
    cyc(); rst = 1'b0; #1;
    check("r0_en",   32'(bus.inst_rd_en),   32'h1);
    check("r0_pcen", 32'(bus.PC_en),        32'h1);
    check("r0_addr", 32'(bus.inst_rd_addr), 32'h0);
    check("r0_vld",  32'(bus.vld),          32'h0);
    cyc();
    check("r1_addr", 32'(bus.inst_rd_addr), 32'h1);
    check("r1_vld",  32'(bus.vld),          32'h0);
    cyc();
    check("r2_vld",   32'(bus.vld),          32'h1);
    check("r2_instr", 32'(bus.instr_out),    32'h10);
    check("r2_cnt",   32'(bus.ocount),       32'h2);
    check("r2_addr",  32'(bus.inst_rd_addr), 32'h2);
    cyc();
    check("r3_instr", 32'(bus.instr_out),    32'h11);
    check("r3_cnt",   32'(bus.ocount),       32'h2);
    check("r3_addr",  32'(bus.inst_rd_addr), 32'h3);
    cyc();
    check("r4_instr", 32'(bus.instr_out),    32'h12);
    check("r4_cnt",   32'(bus.ocount),       32'h2);

    // R5..R9: decode stalls for five cycles; head 0x13 ages 2..6
    for (int i = 0; i < 5; i++) begin
      cyc(); bus.next_rdy = 1'b0; #1;
      check("bp_instr", 32'(bus.instr_out),  32'h13);
      check("bp_cnt",   32'(bus.ocount),     32'(2 + i));
      check("bp_en",    32'(bus.inst_rd_en), 32'h0);
    end

    // R10..R13: release; stream resumes without gap, loss or duplicate
    cyc(); bus.next_rdy = 1'b1; #1;
    check("rel_instr", 32'(bus.instr_out),    32'h13);
    check("rel_cnt",   32'(bus.ocount),       32'h7);
    check("rel_addr",  32'(bus.inst_rd_addr), 32'h5);
    check("rel_en",    32'(bus.inst_rd_en),   32'h1);
    cyc();
    check("r11_instr", 32'(bus.instr_out),    32'h14);
    check("r11_cnt",   32'(bus.ocount),       32'h7);
    check("r11_addr",  32'(bus.inst_rd_addr), 32'h6);
    cyc();
    check("r12_instr", 32'(bus.instr_out), 32'h15);
    check("r12_cnt",   32'(bus.ocount),    32'h2);
    check("r12_vld",   32'(bus.vld),       32'h1);
    cyc();
    check("r13_instr", 32'(bus.instr_out), 32'h16);

    // R14: mispredict with vld, next_rdy and a read in flight
    cyc();
    check("r14_instr", 32'(bus.instr_out), 32'h17);
    bm = 1'b1; bt = 10'h3F0; #1;
    check("mp_en",   32'(bus.inst_rd_en), 32'h0);
    check("mp_pcen", 32'(bus.PC_en),      32'h0);
    check("mp_vld",  32'(bus.vld),        32'h1);
    cyc(); bm = 1'b0; #1;
    check("mp1_vld",  32'(bus.vld),          32'h0);
    check("mp1_addr", 32'(bus.inst_rd_addr), 32'h3F0);
    check("mp1_en",   32'(bus.inst_rd_en),   32'h1);
    cyc();
    check("mp2_vld",  32'(bus.vld),          32'h0);
    check("mp2_addr", 32'(bus.inst_rd_addr), 32'h3F1);
    cyc();
    check("mp3_vld",   32'(bus.vld),       32'h1);
    check("mp3_instr", 32'(bus.instr_out), 32'h00);
    check("mp3_cnt",   32'(bus.ocount),    32'h2);

    // R18..R22: redirect to the last address; PC wraps to zero
    cyc();
    check("mp4_instr", 32'(bus.instr_out), 32'h01);
    bm = 1'b1; bt = 10'h3FF; #1;
    cyc(); bm = 1'b0; #1;
    check("wrap_addr0", 32'(bus.inst_rd_addr), 32'h3FF);
    check("wrap_vld0",  32'(bus.vld),          32'h0);
    cyc();
    check("wrap_addr1", 32'(bus.inst_rd_addr), 32'h000);
    check("wrap_en1",   32'(bus.inst_rd_en),   32'h1);
    cyc();
    check("wrap_instr0", 32'(bus.instr_out), 32'h0F);
    cyc();
    check("wrap_instr1", 32'(bus.instr_out), 32'h10);

    // R23..R102: eighty stalled cycles; head age saturates
    cyc(); bus.next_rdy = 1'b0; #1;
    check("sat_instr0", 32'(bus.instr_out), 32'h11);
    check("sat_cnt0",   32'(bus.ocount),    32'h2);
    for (int i = 1; i < 80; i++) cyc();
    check("sat_cnt",   32'(bus.ocount),     32'(DEF_COUNT_MAX));
    check("sat_instr", 32'(bus.instr_out),  32'h11);
    check("sat_en",    32'(bus.inst_rd_en), 32'h0);
    check("sat_vld",   32'(bus.vld),        32'h1);
    cyc(); bus.next_rdy = 1'b1; #1;
    check("satrel_instr", 32'(bus.instr_out),    32'h11);
    check("satrel_cnt",   32'(bus.ocount),       32'h3F);
    check("satrel_addr",  32'(bus.inst_rd_addr), 32'h3);
    cyc();
    check("satrel1_instr", 32'(bus.instr_out), 32'h12);
    cyc();
    check("satrel2_instr", 32'(bus.instr_out), 32'h13);
    check("satrel2_cnt",   32'(bus.ocount),    32'h2);

    // Reset and mispredict together: reset wins, fetch restarts at 0
    cyc(); rst = 1'b1; bm = 1'b1; bt = 10'h100; #1;
    check("rstmp_en",   32'(bus.inst_rd_en), 32'h0);
    check("rstmp_pcen", 32'(bus.PC_en),      32'h0);
    cyc(); rst = 1'b0; bm = 1'b0; #1;
    check("post_vld",    32'(bus.vld),          32'h0);
    check("post_instr",  32'(bus.instr_out),    32'h0);
    check("post_ocount", 32'(bus.ocount),       32'h0);
    check("post_addr",   32'(bus.inst_rd_addr), 32'h0);
    check("post_en",     32'(bus.inst_rd_en),   32'h1);
    cyc();
    check("post1_addr", 32'(bus.inst_rd_addr), 32'h1);
    check("post1_vld",  32'(bus.vld),          32'h0);
    cyc();
    check("post2_vld",   32'(bus.vld),       32'h1);
    check("post2_instr", 32'(bus.instr_out), 32'h10);
    check("post2_cnt",   32'(bus.ocount),    32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
